// File: rtl/watch_pkg.sv
// Shared types and constants for the stopwatch/timer button sequencer.
//   tm_state_t          : timer lifecycle states
//   FOCUS_SW / FOCUS_TM : values of the focus output
//   DEFAULT_HOLD_MS / DEFAULT_REPEAT_MS : default auto-repeat timing in ms ticks
package watch_pkg;

  typedef enum logic [1:0] {
    T_SET   = 2'd0,
    T_RUN   = 2'd1,
    T_PAUSE = 2'd2,
    T_ALARM = 2'd3
  } tm_state_t;

  localparam logic FOCUS_SW = 1'b0;
  localparam logic FOCUS_TM = 1'b1;

  localparam int unsigned DEFAULT_HOLD_MS   = 500;
  localparam int unsigned DEFAULT_REPEAT_MS = 100;

endpackage

// File: rtl/btn_repeat.sv
// Edge detector with hold/auto-repeat for an increment button.
//   clk, rst_n : clock, async active-low reset
//   ms_tick    : 1 ms strobe
//   btn        : debounced button level
//   en         : button is honoured only while high; low clears the hold count
//   pulse      : registered 1-cycle pulse on press and on every repeat
module btn_repeat
  import watch_pkg::*;
#(
  parameter int unsigned HOLD_MS   = DEFAULT_HOLD_MS,
  parameter int unsigned REPEAT_MS = DEFAULT_REPEAT_MS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick,
  input  logic btn,
  input  logic en,
  output logic pulse
);

  localparam int unsigned MAX_MS = (HOLD_MS > REPEAT_MS) ? HOLD_MS : REPEAT_MS;
  localparam int unsigned CW     = $clog2(MAX_MS + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MS);
  localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_MS);

  logic          btn_q;
  logic          repeating;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;

  // One counter serves both phases: first the hold delay, then the repeat period.
  assign lim = repeating ? REP_LIM : HOLD_LIM;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q     <= 1'b0;
      repeating <= 1'b0;
      cnt       <= '0;
      pulse     <= 1'b0;
    end else begin
      btn_q <= btn;
      pulse <= 1'b0;
      if (!(btn && en)) begin
        cnt       <= '0;
        repeating <= 1'b0;
      end else begin
        if (!btn_q) pulse <= 1'b1;
        if (ms_tick) begin
          if (cnt == lim - CW'(1)) begin
            pulse     <= 1'b1;
            cnt       <= '0;
            repeating <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/watch_ctrl.sv
// Button sequencer for the stopwatch/timer: turns debounced button levels into
// command pulses, runs the timer lifecycle FSM, auto-repeats the increment
// buttons and muxes the focused function's time onto the display.
//   inputs : clk, rst_n, ms_tick, btn_* levels, sw_*/tm_* times, tm_blink
//   outputs: sw_* and tm_* command pulses, tm_en, disp_*, focus (all registered)
module watch_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned HOLD_MS   = DEFAULT_HOLD_MS,
  parameter int unsigned REPEAT_MS = DEFAULT_REPEAT_MS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ms_tick,
  input  logic       btn_mode,
  input  logic       btn_start_stop,
  input  logic       btn_reset,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic [5:0] sw_minutes,
  input  logic [5:0] sw_seconds,
  input  logic [5:0] tm_minutes,
  input  logic [5:0] tm_seconds,
  input  logic       tm_blink,
  output logic       sw_start,
  output logic       sw_stop,
  output logic       sw_reset,
  output logic       tm_en,
  output logic       tm_start,
  output logic       tm_stop,
  output logic       tm_reset,
  output logic       tm_inc_min,
  output logic       tm_inc_sec,
  output logic [5:0] disp_minutes,
  output logic [5:0] disp_seconds,
  output logic       disp_blink,
  output logic       focus
);

  tm_state_t state, state_nxt;
  logic mode_q, ss_q, rst_q;
  // Blocks presses on the first cycle after reset so a button held through
  // reset release is not mistaken for a new press.
  logic armed;
  logic p_mode, p_ss, p_rst;
  logic ss_tm, rst_tm, ss_sw, rst_sw;
  logic sw_run, sw_run_nxt, focus_nxt;
  logic sw_start_nxt, sw_stop_nxt, sw_reset_nxt;
  logic tm_start_nxt, tm_stop_nxt, tm_reset_nxt;
  logic tm_nonzero;

  assign p_mode = armed & btn_mode       & ~mode_q;
  assign p_ss   = armed & btn_start_stop & ~ss_q;
  assign p_rst  = armed & btn_reset      & ~rst_q;

  // A mode press swallows every other press in the same cycle.
  assign ss_tm  = p_ss  & ~p_mode & (focus == FOCUS_TM);
  assign rst_tm = p_rst & ~p_mode & (focus == FOCUS_TM);
  assign ss_sw  = p_ss  & ~p_mode & (focus == FOCUS_SW);
  assign rst_sw = p_rst & ~p_mode & (focus == FOCUS_SW);

  assign tm_nonzero = |{tm_minutes, tm_seconds};

  always_comb begin
    state_nxt    = state;
    focus_nxt    = p_mode ? ~focus : focus;
    sw_run_nxt   = sw_run;
    sw_start_nxt = 1'b0;
    sw_stop_nxt  = 1'b0;
    sw_reset_nxt = 1'b0;
    tm_start_nxt = 1'b0;
    tm_stop_nxt  = 1'b0;
    tm_reset_nxt = 1'b0;

    case (state)
      T_SET: begin
        if (rst_tm) begin
          tm_reset_nxt = 1'b1;
        end else if (ss_tm && tm_nonzero) begin
          tm_start_nxt = 1'b1;
          state_nxt    = T_RUN;
        end
      end
      T_RUN: begin
        // Expiry wins over a stop press and pulls focus to the timer.
        if (tm_blink) begin
          state_nxt = T_ALARM;
          focus_nxt = FOCUS_TM;
        end else if (ss_tm) begin
          tm_stop_nxt = 1'b1;
          state_nxt   = T_PAUSE;
        end
      end
      T_PAUSE: begin
        if (rst_tm) begin
          tm_reset_nxt = 1'b1;
          state_nxt    = T_SET;
        end else if (ss_tm) begin
          tm_start_nxt = 1'b1;
          state_nxt    = T_RUN;
        end
      end
      T_ALARM: begin
        if (rst_tm || ss_tm) begin
          tm_reset_nxt = 1'b1;
          state_nxt    = T_SET;
        end
      end
      default: state_nxt = T_SET;
    endcase

    if (sw_run) begin
      if (ss_sw) begin
        sw_stop_nxt = 1'b1;
        sw_run_nxt  = 1'b0;
      end
    end else if (rst_sw) begin
      sw_reset_nxt = 1'b1;
    end else if (ss_sw) begin
      sw_start_nxt = 1'b1;
      sw_run_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= T_SET;
      mode_q       <= 1'b0;
      ss_q         <= 1'b0;
      rst_q        <= 1'b0;
      armed        <= 1'b0;
      sw_run       <= 1'b0;
      focus        <= FOCUS_SW;
      tm_en        <= 1'b0;
      sw_start     <= 1'b0;
      sw_stop      <= 1'b0;
      sw_reset     <= 1'b0;
      tm_start     <= 1'b0;
      tm_stop      <= 1'b0;
      tm_reset     <= 1'b0;
      disp_minutes <= '0;
      disp_seconds <= '0;
      disp_blink   <= 1'b0;
    end else begin
      mode_q       <= btn_mode;
      ss_q         <= btn_start_stop;
      rst_q        <= btn_reset;
      armed        <= 1'b1;
      state        <= state_nxt;
      sw_run       <= sw_run_nxt;
      focus        <= focus_nxt;
      tm_en        <= (state_nxt == T_SET) && (focus_nxt == FOCUS_TM);
      sw_start     <= sw_start_nxt;
      sw_stop      <= sw_stop_nxt;
      sw_reset     <= sw_reset_nxt;
      tm_start     <= tm_start_nxt;
      tm_stop      <= tm_stop_nxt;
      tm_reset     <= tm_reset_nxt;
      disp_minutes <= (focus == FOCUS_TM) ? tm_minutes : sw_minutes;
      disp_seconds <= (focus == FOCUS_TM) ? tm_seconds : sw_seconds;
      disp_blink   <= tm_blink & focus;
    end
  end

  btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)) u_rep_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .ms_tick(ms_tick),
    .btn    (btn_min),
    .en     (tm_en & ~p_mode),
    .pulse  (tm_inc_min)
  );

  btn_repeat #(.HOLD_MS(HOLD_MS), .REPEAT_MS(REPEAT_MS)) u_rep_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .ms_tick(ms_tick),
    .btn    (btn_sec),
    .en     (tm_en & ~p_mode),
    .pulse  (tm_inc_sec)
  );

endmodule

// File: tb/tb_watch_ctrl.sv
// Scoreboard bench for watch_ctrl: stimulus pushes expected pulse vectors,
// a negedge monitor pops and compares whenever any command pulse is present.
module tb_watch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ms_tick = 1'b0;
  logic [4:0] btns = '0;
  logic [5:0] sw_minutes = '0, sw_seconds = '0, tm_minutes = '0, tm_seconds = '0;
  logic       tm_blink = 1'b0;
  logic sw_start, sw_stop, sw_reset, tm_en, tm_start, tm_stop, tm_reset;
  logic tm_inc_min, tm_inc_sec, disp_blink, focus;
  logic [5:0] disp_minutes, disp_seconds;

  localparam logic [4:0] B_MODE = 5'b10000;
  localparam logic [4:0] B_SS   = 5'b01000;
  localparam logic [4:0] B_RST  = 5'b00100;
  localparam logic [4:0] B_MIN  = 5'b00010;
  localparam logic [4:0] B_SEC  = 5'b00001;

  localparam logic [7:0] P_SW_START = 8'h80;
  localparam logic [7:0] P_SW_STOP  = 8'h40;
  localparam logic [7:0] P_SW_RESET = 8'h20;
  localparam logic [7:0] P_TM_START = 8'h10;
  localparam logic [7:0] P_TM_STOP  = 8'h08;
  localparam logic [7:0] P_TM_RESET = 8'h04;
  localparam logic [7:0] P_INC_MIN  = 8'h02;
  localparam logic [7:0] P_INC_SEC  = 8'h01;

  watch_ctrl #(.HOLD_MS(4), .REPEAT_MS(2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ms_tick       (ms_tick),
    .btn_mode      (btns[4]),
    .btn_start_stop(btns[3]),
    .btn_reset     (btns[2]),
    .btn_min       (btns[1]),
    .btn_sec       (btns[0]),
    .sw_minutes    (sw_minutes),
    .sw_seconds    (sw_seconds),
    .tm_minutes    (tm_minutes),
    .tm_seconds    (tm_seconds),
    .tm_blink      (tm_blink),
    .sw_start      (sw_start),
    .sw_stop       (sw_stop),
    .sw_reset      (sw_reset),
    .tm_en         (tm_en),
    .tm_start      (tm_start),
    .tm_stop       (tm_stop),
    .tm_reset      (tm_reset),
    .tm_inc_min    (tm_inc_min),
    .tm_inc_sec    (tm_inc_sec),
    .disp_minutes  (disp_minutes),
    .disp_seconds  (disp_seconds),
    .disp_blink    (disp_blink),
    .focus         (focus)
  );

  always #5 clk = ~clk;

  logic [7:0] pulses;
  assign pulses = {sw_start, sw_stop, sw_reset, tm_start, tm_stop, tm_reset, tm_inc_min, tm_inc_sec};

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: any visible command pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (pulses !== 8'h00) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got %b expected none", pulses);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("pulse", {24'd0, pulses}, {24'd0, e});
      end
    end
  end

  task automatic press(input logic [4:0] b, input logic [7:0] exp);
    @(negedge clk);
    btns = b;
    if (exp != 8'h00) exp_q.push_back(exp);
    @(negedge clk);
    btns = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with btn_reset held across release: no pulse may follow.
    btns = B_RST;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {9'd0, pulses, tm_en, disp_minutes, disp_seconds, disp_blink, focus}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    btns = '0;
    repeat (2) @(negedge clk);
    chk("idle_outputs", {9'd0, pulses, tm_en, disp_minutes, disp_seconds, disp_blink, focus}, 32'd0);

    // 1. Held start/stop gives exactly one sw_start.
    @(negedge clk);
    btns = B_SS;
    exp_q.push_back(P_SW_START);
    repeat (20) @(negedge clk);
    btns = '0;
    repeat (2) @(negedge clk);
    press(B_SS, P_SW_STOP);

    // 2. Timer set: focus to timer, 5 second increments, held minutes.
    press(B_MODE, 8'h00);
    chk("focus_tm", {31'd0, focus}, 32'd1);
    chk("tm_en_set", {31'd0, tm_en}, 32'd1);
    for (int i = 0; i < 5; i++) press(B_SEC, P_INC_SEC);
    @(negedge clk);
    btns = B_MIN;
    exp_q.push_back(P_INC_MIN);
    repeat (2) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      if (i >= 4 && (i % 2) == 0) exp_q.push_back(P_INC_MIN);
      @(negedge clk) ms_tick = 1'b1;
      @(negedge clk) ms_tick = 1'b0;
      @(negedge clk);
    end
    btns = '0;
    repeat (2) @(negedge clk);

    // 3. Zero guard, then a real start.
    press(B_SS, 8'h00);
    chk("zero_guard_tm_en", {31'd0, tm_en}, 32'd1);
    tm_seconds = 6'd5;
    press(B_SS, P_TM_START);
    chk("run_tm_en", {31'd0, tm_en}, 32'd0);

    // 4. Alarm with stopwatch focused.
    press(B_MODE, 8'h00);
    chk("focus_sw", {31'd0, focus}, 32'd0);
    chk("blink_off", {31'd0, disp_blink}, 32'd0);
    @(negedge clk);
    tm_blink = 1'b1;
    repeat (3) @(negedge clk);
    chk("alarm_focus", {31'd0, focus}, 32'd1);
    chk("alarm_blink", {31'd0, disp_blink}, 32'd1);
    chk("alarm_tm_en", {31'd0, tm_en}, 32'd0);
    press(B_RST, P_TM_RESET);
    chk("alarm_to_set", {31'd0, tm_en}, 32'd1);
    tm_blink = 1'b0;

    // 5. Collisions.
    press(B_SS, P_TM_START);
    @(negedge clk);
    tm_blink = 1'b1;
    btns = B_SS;
    @(negedge clk);
    btns = '0;
    repeat (2) @(negedge clk);
    tm_blink = 1'b0;
    press(B_SS, P_TM_RESET);            // only T_ALARM answers start/stop with reset
    chk("collide_set", {31'd0, tm_en}, 32'd1);
    press(B_SS, P_TM_START);
    press(B_SS, P_TM_STOP);
    press(B_SS | B_RST, P_TM_RESET);    // reset wins in T_PAUSE
    chk("pause_reset", {31'd0, tm_en}, 32'd1);
    press(B_MODE | B_SS, 8'h00);
    chk("mode_ss_focus0", {31'd0, focus}, 32'd0);
    press(B_MODE | B_SS, 8'h00);
    chk("mode_ss_focus1", {31'd0, focus}, 32'd1);
    chk("mode_ss_tm_en", {31'd0, tm_en}, 32'd1);
    press(B_MODE, 8'h00);

    // 6. Stopwatch commands and display mux.
    @(negedge clk);
    sw_minutes = 6'd12;
    sw_seconds = 6'd34;
    tm_minutes = 6'd3;
    tm_seconds = 6'd7;
    repeat (2) @(negedge clk);
    chk("disp_sw_min", {26'd0, disp_minutes}, 32'd12);
    chk("disp_sw_sec", {26'd0, disp_seconds}, 32'd34);
    press(B_SS, P_SW_START);
    press(B_RST, 8'h00);
    press(B_SS, P_SW_STOP);
    press(B_RST, P_SW_RESET);
    sw_seconds = 6'd35;
    chk("disp_latency_pre", {26'd0, disp_seconds}, 32'd34);
    @(negedge clk);
    chk("disp_latency_post", {26'd0, disp_seconds}, 32'd35);
    press(B_MODE, 8'h00);
    chk("disp_tm_min", {26'd0, disp_minutes}, 32'd3);
    chk("disp_tm_sec", {26'd0, disp_seconds}, 32'd7);

    // Asynchronous reset mid-operation.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_focus", {31'd0, focus}, 32'd0);
    chk("async_rst_tm_en", {31'd0, tm_en}, 32'd0);
    chk("async_rst_disp", {20'd0, disp_minutes, disp_seconds}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/watch_ctrl.md
# watch_ctrl

Top-level button sequencer for the stopwatch/timer design. Turns debounced button levels into single-cycle command pulses for the stopwatch and timer datapaths, runs the timer lifecycle FSM (set, run, pause, alarm), auto-repeats the minute and second increment buttons, and muxes the focused function's time onto the display outputs. Sits between the debouncers and the `timer`/stopwatch counters.

## Interface
- `HOLD_MS`, default 500: `ms_tick` count an increment button must be held before auto-repeat starts.
- `REPEAT_MS`, default 100: `ms_tick` period between auto-repeat pulses.
- `clk` input 1: system clock, the only clock. All inputs are synchronous to it.
- `rst_n` input 1: asynchronous, active-low reset.
- `ms_tick` input 1: one-`clk` strobe, once per millisecond.
- `btn_mode`, `btn_start_stop`, `btn_reset`, `btn_min`, `btn_sec` input 1 each: debounced button levels, active high.
- `sw_minutes`, `sw_seconds` input 6 each: stopwatch time.
- `tm_minutes`, `tm_seconds` input 6 each: timer time.
- `tm_blink` input 1: timer expired/alarm flag.
- `sw_start`, `sw_stop`, `sw_reset` output 1 each: stopwatch command pulses.
- `tm_en` output 1: timer set-enable level.
- `tm_start`, `tm_stop`, `tm_reset`, `tm_inc_min`, `tm_inc_sec` output 1 each: timer command pulses.
- `disp_minutes`, `disp_seconds` output 6 each: display time.
- `disp_blink` output 1: display blink.
- `focus` output 1: selected function, 0 = stopwatch, 1 = timer.

## Operation
- **Edge detection:** each button is registered. A press is the cycle where the level is 1 and the registered copy is 0. Holding a button produces no further presses, except for the auto-repeat on `btn_min`/`btn_sec` described below.
- **Focus:**
  - A `btn_mode` press toggles `focus`.
  - When the timer enters T_ALARM, `focus` is forced to 1.
  - `btn_start_stop` and `btn_reset` act only on the focused function.
- **Stopwatch:** a running flag, reset value 0, with focus = 0.
  - `btn_start_stop` press while stopped: `sw_start` pulse, flag set to 1.
  - `btn_start_stop` press while running: `sw_stop` pulse, flag cleared to 0.
  - `btn_reset` press while stopped: `sw_reset` pulse.
  - `btn_reset` press while running: ignored.
  - The stopwatch keeps running while focus = 1.
- **Timer FSM:** states T_SET (reset state), T_RUN, T_PAUSE, T_ALARM.
  - T_SET, `btn_start_stop` with `tm_minutes`/`tm_seconds` not both 0: `tm_start` pulse, go to T_RUN. When both are 0, the press is ignored.
  - T_SET, `btn_reset`: `tm_reset` pulse, stay in T_SET.
  - T_RUN, `btn_start_stop`: `tm_stop` pulse, go to T_PAUSE.
  - T_RUN, `tm_blink` = 1: go to T_ALARM. This applies in every focus.
  - T_RUN, `btn_reset`: ignored.
  - T_PAUSE, `btn_start_stop`: `tm_start` pulse, go to T_RUN.
  - T_PAUSE, `btn_reset`: `tm_reset` pulse, go to T_SET.
  - T_ALARM, `btn_start_stop` or `btn_reset`: `tm_reset` pulse, go to T_SET.
- **Timer set enable:** `tm_en` is 1 only in T_SET with focus = 1.
- **Increment buttons:** `btn_min`/`btn_sec` are active only when `tm_en` = 1. Each button has an independent counter.
  - A press gives one pulse immediately.
  - After `HOLD_MS` ticks of continuous hold, a further pulse is issued every `REPEAT_MS` ticks.
  - Release, or `tm_en` falling, clears the counter.
- **Display:** `disp_minutes`/`disp_seconds` take the stopwatch time when focus = 0 and the timer time when focus = 1. `disp_blink` = `tm_blink` AND focus.
- **Simultaneous events:**
  - `btn_mode` press is processed and all other presses in that cycle are discarded.
  - `btn_reset` beats `btn_start_stop` where reset is legal; otherwise `btn_start_stop` is processed.
  - `tm_blink` in T_RUN beats `btn_start_stop`: no `tm_stop` pulse.

## Timing
- All outputs are registered.
- Every command pulse is exactly 1 `clk` wide and asserts on the cycle after the first clock edge at which the button level samples 1.
- FSM and `focus` updates take effect on that same edge.
- Display mux has 1-cycle latency from the inputs.
- Auto-repeat pulses assert 1 cycle after the qualifying `ms_tick`.
- Reset values of outputs:
  - all pulse outputs 0;
  - `tm_en` 0 (since `focus` resets to 0);
  - `disp_minutes`/`disp_seconds` 0;
  - `disp_blink` 0;
  - `focus` 0.
- Reset values of internal state: timer FSM in T_SET, stopwatch flag 0, repeat counters 0.
- `rst_n` asserted mid-operation returns everything to these values immediately; no pulses are issued on reset release.

## Structure
- Shared package `watch_pkg` holds:
  - `tm_state_t` enum (T_SET, T_RUN, T_PAUSE, T_ALARM);
  - `FOCUS_SW`/`FOCUS_TM` constants;
  - default `HOLD_MS`/`REPEAT_MS`.
- Sub-module `btn_repeat` (parameters `HOLD_MS`, `REPEAT_MS`; ports `clk`, `rst_n`, `ms_tick`, `btn`, `en`, output `pulse`) provides edge detection and hold/repeat counting. It is instantiated twice, for minutes and seconds.

## Test plan
All scenarios run with `HOLD_MS`=4 and `REPEAT_MS`=2.
1. Reset check: `rst_n` low then high, then hold `btn_start_stop` high for 20 cycles -> exactly one `sw_start` pulse; all outputs 0 before the press.
2. Timer set: `btn_mode` press, then 5 `btn_sec` presses -> `tm_en`=1, exactly 5 `tm_inc_sec` pulses, `focus`=1. Then hold `btn_min` for 10 `ms_tick`s -> `tm_inc_min` pulses at press, tick 4, tick 6, tick 8 and tick 10 (5 total).
3. Zero guard: in T_SET with the timer at 0:00, press `btn_start_stop` -> no `tm_start`, FSM stays in T_SET. With 0:05, press -> one `tm_start`, T_RUN, `tm_en`=0.
4. Alarm: in T_RUN with focus switched to 0, raise `tm_blink` -> `focus`=1, `disp_blink`=1. Press `btn_reset` -> one `tm_reset`, T_SET.
5. Collisions: in T_RUN, `tm_blink` and `btn_start_stop` in the same cycle -> T_ALARM, no `tm_stop`. `btn_mode` with `btn_start_stop` -> only `focus` toggles.
6. Stopwatch: start, press `btn_reset` while running -> no `sw_reset`. Stop, press `btn_reset` -> one `sw_reset`. Display shows `sw_*` one cycle after focus = 0.
